// File: rtl/mem_pkg.sv
// Types shared by the BRAM vector read and write paths.
// Holds the default vector geometry, the address type and the reader FSM states.
package mem_pkg;
  localparam int NO_OF_ELEM = 16;
  localparam int WORD_SIZE  = 32;
  localparam int MEM_DEPTH  = 9;
  localparam int IDX_W      = $clog2(NO_OF_ELEM);

  typedef logic [NO_OF_ELEM-1:0][WORD_SIZE-1:0] vec_t;
  typedef logic [MEM_DEPTH-1:0]                 addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;
endpackage

// File: rtl/mem_reader_if.sv
// Request/result and BRAM-side signals of the vector reader.
// master = requester plus BRAM model; slave = mem_reader.
interface mem_reader_if #(
  parameter int NoOfElem = 16,
  parameter int wordSize = 32,
  parameter int memDepth = 9
);
  logic                               start;
  logic [memDepth-1:0]                readAddr;
  logic [wordSize-1:0]                dataInBRAM;
  logic [memDepth-1:0]                readAddrBRAM;
  logic                               readEN;
  logic [NoOfElem-1:0][wordSize-1:0]  dataOut;
  logic                               busy;
  logic                               RDdone;
  logic                               vecValid;

  modport master (
    output start, readAddr, dataInBRAM,
    input  readAddrBRAM, readEN, dataOut, busy, RDdone, vecValid
  );

  modport slave (
    input  start, readAddr, dataInBRAM,
    output readAddrBRAM, readEN, dataOut, busy, RDdone, vecValid
  );
endinterface

// File: rtl/mem_read_tag_pipe.sv
// Delay line of {valid, element index} tags that lines up with the BRAM read data.
// Latency LATENCY clocks; no backpressure, one tag accepted every clock.
module mem_read_tag_pipe #(
  parameter int LATENCY = 1,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_empty
);
  logic [LATENCY-1:0]            r_vld;
  logic [LATENCY-1:0][IDX_W-1:0] r_idx;
  logic                          w_inner_vld;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_vld <= '0;
      r_idx <= '0;
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  // Empty means nothing is queued behind the output stage, so the pipe
  // drains completely once the tag now at the output is consumed.
  always_comb begin
    w_inner_vld = 1'b0;
    for (int i = 0; i < LATENCY - 1; i++) begin
      w_inner_vld = w_inner_vld | r_vld[i];
    end
  end

  assign o_vld   = r_vld[LATENCY-1];
  assign o_idx   = r_idx[LATENCY-1];
  assign o_empty = !w_inner_vld;
endmodule

// File: rtl/mem_reader.sv
// Reads NoOfElem consecutive BRAM words from a base address into one packed vector.
// Start-to-vecValid is NoOfElem+readLatency+1 clocks; start is ignored while busy.
module mem_reader
  import mem_pkg::*;
#(
  parameter int NoOfElem    = NO_OF_ELEM,
  parameter int wordSize    = WORD_SIZE,
  parameter int memDepth    = MEM_DEPTH,
  parameter int readLatency = 1
) (
  input logic          clk,
  input logic          RESET,
  mem_reader_if.slave  bus
);
  localparam int                  LP_IDX_W = $clog2(NoOfElem);
  localparam logic [LP_IDX_W-1:0] LP_LAST  = LP_IDX_W'(NoOfElem - 1);

  state_e                            r_state, w_state_nxt;
  logic                              r_read_en, w_read_en_nxt;
  logic [memDepth-1:0]               r_addr, w_addr_nxt;
  logic [LP_IDX_W-1:0]               r_cnt, w_cnt_nxt;
  logic                              r_busy, w_busy_nxt;
  logic                              r_rd_done, w_rd_done_nxt;
  logic                              r_vec_vld, w_vec_vld_nxt;
  logic [NoOfElem-1:0][wordSize-1:0] r_data;

  logic                w_tag_vld;
  logic [LP_IDX_W-1:0] w_tag_idx;
  logic                w_tag_empty;
  logic                w_last_ret;

  mem_read_tag_pipe #(
    .LATENCY (readLatency),
    .IDX_W   (LP_IDX_W)
  ) u_tag_pipe (
    .clk     (clk),
    .RESET   (RESET),
    .i_vld   (r_read_en),
    .i_idx   (r_cnt),
    .o_vld   (w_tag_vld),
    .o_idx   (w_tag_idx),
    .o_empty (w_tag_empty)
  );

  // Returns come back in issue order, so the final element arriving closes the vector.
  assign w_last_ret = w_tag_vld && (w_tag_idx == LP_LAST) && w_tag_empty;

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_state   <= IDLE;
      r_read_en <= 1'b0;
      r_addr    <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_rd_done <= 1'b1;
      r_vec_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_read_en <= w_read_en_nxt;
      r_addr    <= w_addr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_busy    <= w_busy_nxt;
      r_rd_done <= w_rd_done_nxt;
      r_vec_vld <= w_vec_vld_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_read_en_nxt = 1'b0;
    w_addr_nxt    = r_addr;
    w_cnt_nxt     = r_cnt;
    w_busy_nxt    = r_busy;
    w_rd_done_nxt = r_rd_done;
    w_vec_vld_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_state_nxt   = ISSUE;
          w_read_en_nxt = 1'b1;
          w_addr_nxt    = bus.readAddr;
          w_cnt_nxt     = '0;
          w_busy_nxt    = 1'b1;
          w_rd_done_nxt = 1'b0;
        end
      end
      ISSUE: begin
        // r_cnt is the index of the read being presented this cycle.
        if (r_cnt == LP_LAST) begin
          w_state_nxt = DRAIN;
        end else begin
          w_read_en_nxt = 1'b1;
          w_addr_nxt    = r_addr + 1'b1;
          w_cnt_nxt     = r_cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (w_last_ret) begin
          w_state_nxt   = IDLE;
          w_busy_nxt    = 1'b0;
          w_rd_done_nxt = 1'b1;
          w_vec_vld_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RESET) begin
      r_data <= '0;
    end else if (w_tag_vld) begin
      r_data[w_tag_idx] <= bus.dataInBRAM;
    end
  end

  assign bus.readEN       = r_read_en;
  assign bus.readAddrBRAM = r_addr;
  assign bus.dataOut      = r_data;
  assign bus.busy         = r_busy;
  assign bus.RDdone       = r_rd_done;
  assign bus.vecValid     = r_vec_vld;
endmodule

// File: tb/tb_mem_reader.sv
// Directed bench for mem_reader: one instance at read latency 1, one at latency 3,
// each fed by a BRAM model holding mem[a] = a*3.
module tb_mem_reader;
  import mem_pkg::*;

  logic  clk = 1'b0;
  logic  RESET;
  logic  start;
  addr_t readAddr;
  int    n_chk = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  mem_reader_if ifa ();
  mem_reader_if ifb ();

  mem_reader #(.readLatency(1)) u_dut_a (.clk(clk), .RESET(RESET), .bus(ifa.slave));
  mem_reader #(.readLatency(3)) u_dut_b (.clk(clk), .RESET(RESET), .bus(ifb.slave));

  function automatic logic [31:0] mem_word(input int a);
    return 32'((a % 512) * 3);
  endfunction

  // BRAM models: a read enabled in cycle c is on the data bus during cycle c+latency.
  logic [31:0] a_rd;
  logic [31:0] b_p0, b_p1, b_p2;
  always @(posedge clk) begin
    a_rd <= ifa.readEN ? mem_word(int'(ifa.readAddrBRAM)) : 32'hBAD0_BAD0;
    b_p0 <= ifb.readEN ? mem_word(int'(ifb.readAddrBRAM)) : 32'hBAD1_BAD1;
    b_p1 <= b_p0;
    b_p2 <= b_p1;
  end

  assign ifa.start      = start;
  assign ifa.readAddr   = readAddr;
  assign ifa.dataInBRAM = a_rd;
  assign ifb.start      = start;
  assign ifb.readAddr   = readAddr;
  assign ifb.dataInBRAM = b_p2;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t exp_vec(input int base);
    vec_t v;
    for (int i = 0; i < NO_OF_ELEM; i++) v[i] = mem_word(base + i);
    return v;
  endfunction

  task automatic start_burst(input int base);
    start    = 1'b1;
    readAddr = addr_t'(base);
  endtask

  task automatic check_cycle(input int c, input int base, input bit chk_b);
    addr_t a_exp;
    a_exp = addr_t'(base + ((c <= 16) ? c - 1 : 15));
    chk($sformatf("A.readEN c%0d", c), ifa.readEN, c <= 16);
    if (c <= 22) chk($sformatf("A.addr c%0d", c), ifa.readAddrBRAM, a_exp);
    chk($sformatf("A.vecValid c%0d", c), ifa.vecValid, c == 18);
    chk($sformatf("A.busy c%0d", c), ifa.busy, c <= 17);
    chk($sformatf("A.RDdone c%0d", c), ifa.RDdone, c >= 18);
    if (c == 18) chk("A.dataOut", ifa.dataOut, exp_vec(base));
    if (chk_b) begin
      chk($sformatf("B.readEN c%0d", c), ifb.readEN, c <= 16);
      if (c <= 16) chk($sformatf("B.addr c%0d", c), ifb.readAddrBRAM, a_exp);
      chk($sformatf("B.vecValid c%0d", c), ifb.vecValid, c == 20);
      chk($sformatf("B.busy c%0d", c), ifb.busy, c <= 19);
      chk($sformatf("B.RDdone c%0d", c), ifb.RDdone, c >= 20);
      if (c == 20) chk("B.dataOut", ifb.dataOut, exp_vec(base));
    end
  endtask

  // Called at the negedge where start was driven; cycle 1 follows the start edge.
  task automatic track(input int base, input int stop_at, input bit chk_b,
                       input bit pulse_busy, input int reset_at, input bit restart);
    for (int c = 1; c <= stop_at; c++) begin
      @(negedge clk);
      check_cycle(c, base, chk_b);
      if (c == 1) start = 1'b0;
      if (pulse_busy && (c == 5 || c == 10)) begin
        start    = 1'b1;
        readAddr = 9'h055;
      end
      if (pulse_busy && (c == 6 || c == 11)) start = 1'b0;
      if (c == reset_at) begin
        RESET = 1'b0;
        return;
      end
      if (restart && c == 18) begin
        start    = 1'b1;
        readAddr = 9'h100;
      end
    end
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, ".A.readEN"}, ifa.readEN, 1'b0);
    chk({tag, ".A.addr"}, ifa.readAddrBRAM, 9'h000);
    chk({tag, ".A.dataOut"}, ifa.dataOut, '0);
    chk({tag, ".A.busy"}, ifa.busy, 1'b0);
    chk({tag, ".A.RDdone"}, ifa.RDdone, 1'b1);
    chk({tag, ".A.vecValid"}, ifa.vecValid, 1'b0);
    chk({tag, ".B.vecValid"}, ifb.vecValid, 1'b0);
    chk({tag, ".B.dataOut"}, ifb.dataOut, '0);
  endtask

  initial begin
    RESET    = 1'b0;
    start    = 1'b1;
    readAddr = 9'h123;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_reset($sformatf("reset%0d", i));
    end
    RESET = 1'b1;
    start = 1'b0;
    @(negedge clk);

    start_burst(9'h010);
    track(9'h010, 22, 1'b1, 1'b0, 0, 1'b0);

    start_burst(9'h1F8);
    track(9'h1F8, 22, 1'b1, 1'b0, 0, 1'b0);
    chk("wrap.elem8", ifa.dataOut[8], mem_word(0));
    chk("wrap.elem7", ifa.dataOut[7], mem_word(9'h1FF));

    start_burst(9'h020);
    track(9'h020, 22, 1'b1, 1'b1, 0, 1'b0);

    start_burst(9'h030);
    track(9'h030, 18, 1'b0, 1'b0, 0, 1'b1);
    track(9'h100, 22, 1'b0, 1'b0, 0, 1'b0);

    start_burst(9'h040);
    track(9'h040, 22, 1'b0, 1'b0, 8, 1'b0);
    for (int c = 9; c <= 18; c++) begin
      @(negedge clk);
      check_idle_reset($sformatf("midreset c%0d", c));
      if (c == 9) RESET = 1'b1;
    end

    start_burst(9'h0A0);
    track(9'h0A0, 22, 1'b1, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
